// File: rtl/shift_pla_pkg.sv
// Shared definitions for the shift-only tanh PLA (forward) and its inverse.
// Holds the inverse-FSM state encoding, the default word geometry and the
// derived-width helpers used by both directions.
package shift_pla_pkg;

  // Default geometry: y is Q1.(DEF_W_IN-1), x is Q(DEF_OUT_I).(DEF_W_OUT-DEF_OUT_I)
  localparam int unsigned DEF_W_IN  = 8;
  localparam int unsigned DEF_W_OUT = 8;
  localparam int unsigned DEF_OUT_I = 4;

  // Inverse datapath sequencing
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNT    = 2'd1,
    ASSEMBLE = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Fraction bits of the x-domain word
  function automatic int unsigned calc_out_f(input int unsigned w_out,
                                             input int unsigned out_i);
    return w_out - out_i;
  endfunction

  // Largest integer part representable in x (sign bit excluded)
  function automatic int unsigned calc_k_max(input int unsigned out_i);
    return (32'd1 << (out_i - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/shift_pla_align.sv
// Result formation for the shift-only tanh inverse.
// Takes the magnitude bits left over after the terminating zero (already
// left-aligned by the counting shifts), the leading-ones count k and the
// input sign, and produces the saturated, signed x word.
//   mag  : remaining magnitude bits, MSB-aligned
//   k    : leading-ones count (integer part of x)
//   sgn  : sign of the original y
//   x_c  : signed result, Q(OUT_I).(OUT_F)
module shift_pla_align
  import shift_pla_pkg::*;
#(
  parameter int unsigned W_IN  = DEF_W_IN,
  parameter int unsigned W_OUT = DEF_W_OUT,
  parameter int unsigned OUT_I = DEF_OUT_I,
  parameter int unsigned K_W   = $clog2(W_IN)
) (
  input  logic [W_IN-2:0]  mag,
  input  logic [K_W-1:0]   k,
  input  logic             sgn,
  output logic [W_OUT-1:0] x_c
);

  localparam int unsigned M_W   = W_IN - 1;
  localparam int unsigned OUT_F = calc_out_f(W_OUT, OUT_I);
  localparam int unsigned K_MAX = calc_k_max(OUT_I);
  localparam int unsigned EXT_W = M_W + OUT_F;

  logic [EXT_W-1:0] ext;
  logic [OUT_F-1:0] frac;
  logic             sat;
  logic [W_OUT-1:0] mag_res;
  logic             unused_low_bits;

  // Zero-fill below the magnitude so short remainders pad with zeros and
  // long ones are truncated by taking only the top OUT_F bits.
  assign ext             = {mag, {OUT_F{1'b0}}};
  assign frac            = ext[EXT_W-1 -: OUT_F];
  assign unused_low_bits = ^ext[M_W-1:0];

  // No terminating zero found, or integer part too large for x
  assign sat = (32'(k) >= M_W) || (32'(k) > K_MAX);

  // Unsigned magnitude of x
  always_comb begin
    mag_res = {OUT_I'(k), frac};
    if (sat) begin
      mag_res = {1'b0, {(W_OUT-1){1'b1}}};
    end
  end

  // Apply sign
  assign x_c = sgn ? (~mag_res + W_OUT'(1)) : mag_res;

endmodule

// File: rtl/shift_pla_inverse.sv
// Iterative shift-only inverse of the tanh PLA approximation.
// Maps y (Q1.(W_IN-1)) back to x (Q(OUT_I).(OUT_F)) by counting the leading
// ones of |y| one bit per clock, then using the bits after the terminating
// zero as the fraction. One operation in flight, valid/ready on both sides.
//   clock, resetn        : rising-edge clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake, in_ready high only while idle
//   in_data              : y, two's complement
//   out_valid/out_ready  : output handshake, result held until accepted
//   out_data             : x, two's complement
module shift_pla_inverse
  import shift_pla_pkg::*;
#(
  parameter int unsigned W_IN  = DEF_W_IN,
  parameter int unsigned W_OUT = DEF_W_OUT,
  parameter int unsigned OUT_I = DEF_OUT_I
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] out_data
);

  localparam int unsigned M_W = W_IN - 1;
  localparam int unsigned K_W = $clog2(W_IN);

  state_e           state_q, state_d;
  logic             sgn_q, sgn_d;
  logic [M_W-1:0]   mag_q, mag_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [W_OUT-1:0] out_data_q, out_data_d;

  logic [W_IN-1:0]  y_abs;
  logic [M_W-1:0]   mag_in;
  logic [W_OUT-1:0] x_c;

  // |y|; the most negative y overflows into the MSB, so it is forced to an
  // all-ones magnitude and therefore runs the full count and saturates.
  assign y_abs  = in_data[W_IN-1] ? (~in_data + W_IN'(1)) : in_data;
  assign mag_in = y_abs[W_IN-1] ? {M_W{1'b1}} : y_abs[M_W-1:0];

  shift_pla_align #(
    .W_IN  (W_IN),
    .W_OUT (W_OUT),
    .OUT_I (OUT_I),
    .K_W   (K_W)
  ) u_align (
    .mag (mag_q),
    .k   (k_q),
    .sgn (sgn_q),
    .x_c (x_c)
  );

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      sgn_q       <= 1'b0;
      mag_q       <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sgn_q       <= sgn_d;
      mag_q       <= mag_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    sgn_d       = sgn_q;
    mag_d       = mag_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sgn_d   = in_data[W_IN-1];
          mag_d   = mag_in;
          k_d     = '0;
          state_d = COUNT;
        end
      end

      COUNT: begin
        // Shift out one leading one per cycle; the last possible one ends
        // the count directly since no terminating zero can follow it.
        if (mag_q[M_W-1] && (32'(k_q) < M_W)) begin
          mag_d = mag_q << 1;
          k_d   = k_q + K_W'(1);
          if (32'(k_q) + 32'd1 == M_W) begin
            state_d = ASSEMBLE;
          end
        end else begin
          // Consume the terminating zero so the fraction is MSB-aligned
          mag_d   = mag_q << 1;
          state_d = ASSEMBLE;
        end
      end

      ASSEMBLE: begin
        out_data_d  = x_c;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
